uart_rx_cfg: RTL and testbench

Parametrised UART receiver and next-generation successor of the fixed 8N1 receiver. It supports configurable clock/baud ratio, data width (5-9 bits), parity (none/even/odd) and 1 or 2 stop bits. Framing and parity errors are reported separately, and a stop-bit glitch is detected. The block sits between the board rx pin and the byte consumer; it runs in the 50 MHz system domain.

---
 rtl/uart_rx_cfg.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to use a 2-of-3 vote around every mid-bit sample point.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk50m,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 rx_error,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_idle
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_EN
    localparam int START_AT = HALF_BIT + 1;
`else
    localparam int START_AT = HALF_BIT;
`endif

    localparam logic [CNT_W-1:0] START_END = CNT_W'(START_AT);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_END  = CNT_W'(CLKS_PER_BIT - HALF_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state, state_next;
    logic [1:0]           sync_q;
    logic                 rxs, rxs_prev;
    logic                 start_edge;
    logic                 bit_val;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [1:0]           stop_idx;
    logic                 stop_mon;
    logic                 stop_done;
    logic [DATA_BITS-1:0] shreg;
    logic                 frame_flag, par_flag;

    function automatic logic parity_ok(input logic [DATA_BITS-1:0] word, input logic pbit);
        logic ones;
        ones = ^word;
        if (PARITY == 2) return pbit == ~ones;
        return pbit == ones;
    endfunction

    assign rxs        = sync_q[1];
    assign start_edge = rxs_prev & ~rxs;
    assign rx_idle    = (state == S_IDLE);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[0], rx};
            rxs_prev <= rxs;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Two previous rxs samples; together with the current one they span mid-1..mid+1.
    logic [1:0] hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rxs};
    end

    assign bit_val = maj3(hist[1], hist[0], rxs);
`else
    assign bit_val = rxs;
`endif

    // Stop window ends at mid of the last stop bit; earlier stop bits run a full bit.
    assign stop_done = stop_mon && (stop_idx == STOP_LAST) && (cnt == LAST_END);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_edge) state_next = S_START;
            S_START:  if (cnt == START_END) state_next = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (cnt == BIT_END && bit_idx == DATA_LAST)
                          state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (cnt == BIT_END) state_next = S_STOP;
            S_STOP:   if (stop_done) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            bit_idx       <= '0;
            stop_idx      <= '0;
            stop_mon      <= 1'b0;
            shreg         <= '0;
            frame_flag    <= 1'b0;
            par_flag      <= 1'b0;
            rx_data       <= '0;
            rx_ready      <= 1'b0;
            rx_error      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= '0;
                    stop_mon <= 1'b0;
                    if (start_edge) begin
                        rx_ready      <= 1'b0;
                        rx_error      <= 1'b0;
                        rx_frame_err  <= 1'b0;
                        rx_parity_err <= 1'b0;
                        frame_flag    <= 1'b0;
                        par_flag      <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt == START_END) cnt <= '0;
                    else                  cnt <= cnt + 1'b1;
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt      <= '0;
                        par_flag <= ~parity_ok(shreg, bit_val);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (!stop_mon) begin
                        // Half a bit from the last mid-bit sample reaches the stop-bit boundary.
                        if (cnt == HALF_END) begin
                            cnt      <= '0;
                            stop_mon <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        if (!rxs) frame_flag <= 1'b1;
                        if (stop_done) begin
                            cnt <= '0;
                        end else if (stop_idx != STOP_LAST && cnt == BIT_END) begin
                            cnt      <= '0;
                            stop_idx <= stop_idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (frame_flag || par_flag) begin
                        rx_data       <= '0;
                        rx_ready      <= 1'b0;
                        rx_frame_err  <= frame_flag;
                        rx_parity_err <= par_flag;
                        rx_error      <= 1'b1;
                    end else begin
                        rx_data  <= shreg;
                        rx_ready <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7O2 at 1 Mbaud) against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int B0 = 8680;
    localparam int B2 = 1000;

    typedef struct packed {
        logic [8:0] data;
        logic       ready;
        logic       ferr;
        logic       perr;
        logic       err;
    } exp_t;

    logic       clk50m;
    logic       rst_n;
    logic [2:0] rx_v;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] d0_data, d1_data;
    logic [6:0] d2_data;
    logic       d0_ready, d0_err, d0_ferr, d0_perr, d0_idle;
    logic       d1_ready, d1_err, d1_ferr, d1_perr, d1_idle;
    logic       d2_ready, d2_err, d2_ferr, d2_perr, d2_idle;

    uart_rx_cfg u_dut0 (
        .clk50m(clk50m), .rst_n(rst_n), .rx(rx_v[0]), .rx_data(d0_data),
        .rx_ready(d0_ready), .rx_error(d0_err), .rx_frame_err(d0_ferr),
        .rx_parity_err(d0_perr), .rx_idle(d0_idle)
    );

    uart_rx_cfg #(.PARITY(1)) u_dut1 (
        .clk50m(clk50m), .rst_n(rst_n), .rx(rx_v[1]), .rx_data(d1_data),
        .rx_ready(d1_ready), .rx_error(d1_err), .rx_frame_err(d1_ferr),
        .rx_parity_err(d1_perr), .rx_idle(d1_idle)
    );

    uart_rx_cfg #(.BAUD(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk50m(clk50m), .rst_n(rst_n), .rx(rx_v[2]), .rx_data(d2_data),
        .rx_ready(d2_ready), .rx_error(d2_err), .rx_frame_err(d2_ferr),
        .rx_parity_err(d2_perr), .rx_idle(d2_idle)
    );

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] mask(input logic [8:0] d, input int nbits);
        return d & 9'((1 << nbits) - 1);
    endfunction

    function automatic logic good_pbit(input logic [8:0] d, input int nbits, input int pmode);
        return (pmode == 2) ? ~^mask(d, nbits) : ^mask(d, nbits);
    endfunction

    // Frame-level expectation from what was put on the line.
    function automatic exp_t model(input logic [8:0] d, input int nbits, input int pmode,
                                   input logic pbit, input logic glitch);
        exp_t e;
        logic [8:0] m;
        m      = mask(d, nbits);
        e.perr = (pmode != 0) && (pbit != good_pbit(d, nbits, pmode));
        e.ferr = glitch;
        e.err  = e.perr | e.ferr;
        e.ready = ~e.err;
        e.data = e.ready ? m : 9'd0;
        return e;
    endfunction

    task automatic check_outputs(input int idx, input string tag, input exp_t e);
        logic [8:0] data;
        logic rdy, err, fe, pe, idl;
        case (idx)
            0:       begin data = {1'b0, d0_data}; rdy = d0_ready; err = d0_err; fe = d0_ferr; pe = d0_perr; idl = d0_idle; end
            1:       begin data = {1'b0, d1_data}; rdy = d1_ready; err = d1_err; fe = d1_ferr; pe = d1_perr; idl = d1_idle; end
            default: begin data = {2'b0, d2_data}; rdy = d2_ready; err = d2_err; fe = d2_ferr; pe = d2_perr; idl = d2_idle; end
        endcase
        check({tag, "_data"}, 32'(data), 32'(e.data));
        check({tag, "_ready"}, 32'(rdy), 32'(e.ready));
        check({tag, "_error"}, 32'(err), 32'(e.err));
        check({tag, "_frame"}, 32'(fe), 32'(e.ferr));
        check({tag, "_parity"}, 32'(pe), 32'(e.perr));
        check({tag, "_idle"}, 32'(idl), 32'd1);
    endtask

    // Line transitions land 5 ns before a rising edge so every pulse is captured cleanly.
    task automatic align();
        @(negedge clk50m);
        #5;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk50m);
    endtask

    task automatic send_frame(input int idx, input logic [8:0] d, input int nbits, input int pmode,
                              input logic pbit, input int nstop, input int bit_ns,
                              input int g_off, input int g_len);
        rx_v[idx] = 1'b0;
        #(bit_ns);
        for (int i = 0; i < nbits; i++) begin
            rx_v[idx] = d[i];
            #(bit_ns);
        end
        if (pmode != 0) begin
            rx_v[idx] = pbit;
            #(bit_ns);
        end
        rx_v[idx] = 1'b1;
        if (g_off >= 0) begin
            #(g_off);
            rx_v[idx] = 1'b0;
            #(g_len);
            rx_v[idx] = 1'b1;
            #(nstop * bit_ns - g_off - g_len);
        end else begin
            #(nstop * bit_ns);
        end
    endtask

    initial begin
        logic [8:0] d;
        logic       pb, gl;
        int         goff, glen;

        rst_n = 1'b0;
        rx_v  = 3'b111;
        repeat (3) @(negedge clk50m);
        check_outputs(0, "rst0", '0);
        check_outputs(2, "rst2", '0);
        align();
        rst_n = 1'b1;
        repeat (4) @(negedge clk50m);

        align();
        send_frame(0, 9'h55, 8, 0, 1'b0, 1, B0, -1, 0);
        settle();
        check_outputs(0, "n81_55", model(9'h55, 8, 0, 1'b0, 1'b0));

        // Short low pulse: start bit rejected at its midpoint.
        align();
        rx_v[0] = 1'b0;
        #1000;
        check("fs_busy", 32'(d0_idle), 32'd0);
        #1000;
        rx_v[0] = 1'b1;
        #3400;
        settle();
        check("fs_data", 32'(d0_data), 32'h55);
        check("fs_error", 32'(d0_err), 32'd0);
        check("fs_frame", 32'(d0_ferr), 32'd0);
        check("fs_parity", 32'(d0_perr), 32'd0);
        check("fs_idle", 32'(d0_idle), 32'd1);

        align();
        send_frame(0, 9'h55, 8, 0, 1'b0, 1, B0, 2000, 40);
        settle();
        check_outputs(0, "n81_glitch", model(9'h55, 8, 0, 1'b0, 1'b1));

        // Reset in the middle of data bit 4, held until the line is idle again.
        align();
        fork
            send_frame(0, 9'hA5, 8, 0, 1'b0, 1, B0, -1, 0);
            begin
                #(5 * B0 + B0 / 2);
                rst_n = 1'b0;
                #1;
                check_outputs(0, "rst_mid", '0);
            end
        join
        align();
        rst_n = 1'b1;
        settle();
        check("rst_rel_idle", 32'(d0_idle), 32'd1);
        align();
        send_frame(0, 9'h0F, 8, 0, 1'b0, 1, B0, -1, 0);
        settle();
        check_outputs(0, "rst_0f", model(9'h0F, 8, 0, 1'b0, 1'b0));

        align();
        send_frame(1, 9'hA3, 8, 1, 1'b0, 1, B0, -1, 0);
        settle();
        check_outputs(1, "e81_ok", model(9'hA3, 8, 1, 1'b0, 1'b0));
        align();
        send_frame(1, 9'hA3, 8, 1, 1'b1, 1, B0, -1, 0);
        settle();
        check_outputs(1, "e81_bad", model(9'hA3, 8, 1, 1'b1, 1'b0));

        for (int n = 0; n < 2; n++) begin
            d    = 9'($urandom_range(0, 255));
            pb   = 1'($urandom_range(0, 1));
            gl   = ($urandom_range(0, 2) == 0);
            goff = 20 * $urandom_range(10, 200);
            glen = 20 * $urandom_range(1, 3);
            align();
            send_frame(1, d, 8, 1, pb, 1, B0, gl ? goff : -1, glen);
            settle();
            check_outputs(1, "e81_rnd", model(d, 8, 1, pb, gl));
        end

        // Back-to-back 7O2 frames: second start follows the first stop bits directly.
        align();
        fork
            begin
                send_frame(2, 9'h3C, 7, 2, good_pbit(9'h3C, 7, 2), 2, B2, -1, 0);
                send_frame(2, 9'h41, 7, 2, good_pbit(9'h41, 7, 2), 2, B2, -1, 0);
            end
            begin
                #10800;
                check("b2b_first_data", 32'(d2_data), 32'h3C);
                check("b2b_first_ready", 32'(d2_ready), 32'd1);
                #500;
                check("b2b_clr_ready", 32'(d2_ready), 32'd0);
                check("b2b_hold_data", 32'(d2_data), 32'h3C);
                check("b2b_busy", 32'(d2_idle), 32'd0);
            end
        join
        settle();
        check_outputs(2, "b2b_second", model(9'h41, 7, 2, good_pbit(9'h41, 7, 2), 1'b0));

        for (int n = 0; n < 30; n++) begin
            d    = 9'($urandom_range(0, 127));
            pb   = good_pbit(d, 7, 2) ^ ($urandom_range(0, 3) == 0);
            gl   = ($urandom_range(0, 3) == 0);
            goff = 20 * $urandom_range(10, 60);
            glen = 20 * $urandom_range(1, 3);
            align();
            send_frame(2, d, 7, 2, pb, 2, B2, gl ? goff : -1, glen);
            settle();
            check_outputs(2, "o72_rnd", model(d, 7, 2, pb, gl));
            #(1000 * $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
